// File: rtl/edge_skew_meter_if.sv
// Port bundle for edge_skew_meter: start/waveform inputs and per-channel delay results.
// Channel bit order on 3-bit vectors is [2]=R [1]=G [0]=B.
interface edge_skew_meter_if;
  logic       start;
  logic [2:0] ref_in;
  logic [2:0] rx_in;
  logic [3:0] rising_delay_r;
  logic [3:0] rising_delay_g;
  logic [3:0] rising_delay_b;
  logic [3:0] falling_delay_r;
  logic [3:0] falling_delay_g;
  logic [3:0] falling_delay_b;
  logic [2:0] meas_busy;
  logic [2:0] meas_done;
  logic [2:0] meas_err;

  modport master (
    output start, ref_in, rx_in,
    input  rising_delay_r, rising_delay_g, rising_delay_b,
    input  falling_delay_r, falling_delay_g, falling_delay_b,
    input  meas_busy, meas_done, meas_err
  );

  modport slave (
    input  start, ref_in, rx_in,
    output rising_delay_r, rising_delay_g, rising_delay_b,
    output falling_delay_r, falling_delay_g, falling_delay_b,
    output meas_busy, meas_done, meas_err
  );
endinterface

// File: rtl/edge_skew_meter.sv
// Per-channel rise/fall edge skew meter: averages ref->rx edge delays in clk_x10 cycles.
// Optional RX_GLITCH_FILT_EN adds a 3-sample majority filter on rx (ref delayed to match).
//
// state   | meaning
// IDLE    | no measurement, trackers frozen
// MEASURE | trackers collecting rise/fall samples
// DONE    | averaged result latched on outputs
module edge_skew_meter #(
  parameter int LOG2_EDGES = 3,
  parameter int MAX_WAIT   = 15,
  parameter int DELAY_MAX  = 9
) (
  input logic               clk_x10,
  input logic               g_rst,
  edge_skew_meter_if.slave  bus
);

  localparam int N  = 1 << LOG2_EDGES;
  localparam int AW = 4 + LOG2_EDGES;
  localparam int CW = LOG2_EDGES + 1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  logic [2:0] ref_q, ref_p, rx_q, rx_p;
  logic [2:0] ref_cur, rx_cur;

`ifdef RX_GLITCH_FILT_EN
  logic [2:0] ref_d, rx_s1, rx_s2;

  // Majority of three samples settles one cycle after a clean step, so ref gets one extra stage.
  assign rx_cur  = (rx_q & rx_s1) | (rx_q & rx_s2) | (rx_s1 & rx_s2);
  assign ref_cur = ref_d;

  always_ff @(posedge clk_x10 or posedge g_rst) begin
    if (g_rst) begin
      ref_q <= '0; ref_d <= '0; ref_p <= '0;
      rx_q  <= '0; rx_s1 <= '0; rx_s2 <= '0; rx_p <= '0;
    end else begin
      ref_q <= bus.ref_in;
      ref_d <= ref_q;
      ref_p <= ref_d;
      rx_q  <= bus.rx_in;
      rx_s1 <= rx_q;
      rx_s2 <= rx_s1;
      rx_p  <= rx_cur;
    end
  end
`else
  assign rx_cur  = rx_q;
  assign ref_cur = ref_q;

  always_ff @(posedge clk_x10 or posedge g_rst) begin
    if (g_rst) begin
      ref_q <= '0; ref_p <= '0;
      rx_q  <= '0; rx_p  <= '0;
    end else begin
      ref_q <= bus.ref_in;
      ref_p <= ref_q;
      rx_q  <= bus.rx_in;
      rx_p  <= rx_q;
    end
  end
`endif

  logic [2:0] ref_rise, ref_fall, rx_rise, rx_fall;
  assign ref_rise = ref_cur & ~ref_p;
  assign ref_fall = ~ref_cur & ref_p;
  assign rx_rise  = rx_cur & ~rx_p;
  assign rx_fall  = ~rx_cur & rx_p;

  function automatic logic [3:0] clamp_avg(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> LOG2_EDGES;
    if (s > AW'(DELAY_MAX)) return 4'(DELAY_MAX);
    return s[3:0];
  endfunction

  logic [2:0] busy_v, done_v, err_v;
  logic [3:0] rise_v [3];
  logic [3:0] fall_v [3];

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    state_t        st, nx;
    logic [CW-1:0] cnt      [2];
    logic [AW-1:0] acc      [2];
    logic [3:0]    wait_cnt [2];
    logic [3:0]    res_q    [2];
    logic [1:0]    pend, tout, ref_e, rx_e;
    logic          err_q, active;

    // Index 0 is the rise tracker, index 1 the fall tracker.
    assign ref_e  = {ref_fall[ch], ref_rise[ch]};
    assign rx_e   = {rx_fall[ch], rx_rise[ch]};
    assign active = (st == MEASURE);

    always_comb begin
      tout = '0;
      for (int p = 0; p < 2; p++) begin
        if (active && cnt[p] != CW'(N) && !ref_e[p] && pend[p] && !rx_e[p] &&
            wait_cnt[p] == 4'(MAX_WAIT))
          tout[p] = 1'b1;
      end
    end

    always_ff @(posedge clk_x10 or posedge g_rst) begin
      if (g_rst) begin
        pend <= '0;
        for (int p = 0; p < 2; p++) begin
          cnt[p] <= '0; acc[p] <= '0; wait_cnt[p] <= '0;
        end
      end else if (bus.start) begin
        pend <= '0;
        for (int p = 0; p < 2; p++) begin
          cnt[p] <= '0; acc[p] <= '0; wait_cnt[p] <= '0;
        end
      end else if (active) begin
        for (int p = 0; p < 2; p++) begin
          if (cnt[p] != CW'(N)) begin
            if (ref_e[p]) begin
              if (rx_e[p]) begin
                cnt[p]  <= cnt[p] + CW'(1);
                pend[p] <= 1'b0;
              end else begin
                pend[p]     <= 1'b1;
                wait_cnt[p] <= 4'd1;
              end
            end else if (pend[p]) begin
              if (rx_e[p]) begin
                acc[p]  <= acc[p] + {{LOG2_EDGES{1'b0}}, wait_cnt[p]};
                cnt[p]  <= cnt[p] + CW'(1);
                pend[p] <= 1'b0;
              end else if (tout[p]) begin
                pend[p] <= 1'b0;
              end else begin
                wait_cnt[p] <= wait_cnt[p] + 4'd1;
              end
            end
          end
        end
      end
    end

    always_ff @(posedge clk_x10 or posedge g_rst) begin
      if (g_rst) st <= IDLE;
      else       st <= nx;
    end

    always_comb begin
      nx = st;
      if (bus.start)
        nx = MEASURE;
      else if (st == MEASURE && cnt[0] == CW'(N) && cnt[1] == CW'(N))
        nx = DONE;
    end

    always_ff @(posedge clk_x10 or posedge g_rst) begin
      if (g_rst) begin
        res_q[0] <= '0;
        res_q[1] <= '0;
      end else if (st == MEASURE && nx == DONE) begin
        res_q[0] <= clamp_avg(acc[0]);
        res_q[1] <= clamp_avg(acc[1]);
      end
    end

    always_ff @(posedge clk_x10 or posedge g_rst) begin
      if (g_rst)          err_q <= 1'b0;
      else if (bus.start) err_q <= 1'b0;
      else if (|tout)     err_q <= 1'b1;
    end

    assign busy_v[ch] = (st == MEASURE);
    assign done_v[ch] = (st == DONE);
    assign err_v[ch]  = err_q;
    assign rise_v[ch] = res_q[0];
    assign fall_v[ch] = res_q[1];
  end

  assign bus.meas_busy       = busy_v;
  assign bus.meas_done       = done_v;
  assign bus.meas_err        = err_v;
  assign bus.rising_delay_r  = rise_v[2];
  assign bus.rising_delay_g  = rise_v[1];
  assign bus.rising_delay_b  = rise_v[0];
  assign bus.falling_delay_r = fall_v[2];
  assign bus.falling_delay_g = fall_v[1];
  assign bus.falling_delay_b = fall_v[0];

endmodule

// File: tb/tb_edge_skew_meter.sv
// Directed bench for edge_skew_meter: per-channel pulse trains with chosen rise/fall skews.
// Pulse period is 20 cycles, ref high for the first 10.
module tb_edge_skew_meter;

  logic clk_x10 = 1'b0;
  logic g_rst   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  edge_skew_meter_if bus ();

  edge_skew_meter dut (
    .clk_x10 (clk_x10),
    .g_rst   (g_rst),
    .bus     (bus)
  );

  always #5 clk_x10 = ~clk_x10;

  // Per-channel stimulus settings, index 2=R 1=G 0=B.
  int dr [3];
  int df [3];
  int np [3];
  bit stuck  [3];
  bit alt    [3];
  bit glitch [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int r, input int f, input int n);
    dr[ch] = r; df[ch] = f; np[ch] = n;
    stuck[ch] = 1'b0; alt[ch] = 1'b0; glitch[ch] = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_x10);
    bus.start = 1'b1;
    @(negedge clk_x10);
    bus.start = 1'b0;
  endtask

  task automatic run_wave(input int ncyc);
    logic [2:0] r, x;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk_x10);
      for (int ch = 0; ch < 3; ch++) begin
        int k, ph, d;
        k  = cyc / 20;
        ph = cyc % 20;
        d  = alt[ch] ? ((k % 2 == 1) ? 3 : 2) : dr[ch];
        r[ch] = (k < np[ch]) && (ph < 10);
        x[ch] = !stuck[ch] && (k < np[ch]) &&
                ((ph >= d && ph < 10 + df[ch]) || (glitch[ch] && ph == 2));
      end
      bus.ref_in = r;
      bus.rx_in  = x;
    end
    @(negedge clk_x10);
    bus.ref_in = '0;
    bus.rx_in  = '0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.ref_in = '0;
    bus.rx_in  = '0;
    for (int ch = 0; ch < 3; ch++) set_ch(ch, 0, 0, 0);
    repeat (3) @(negedge clk_x10);
    g_rst = 1'b0;
    @(negedge clk_x10);
    check("rst_busy", 32'(bus.meas_busy), 0);
    check("rst_done", 32'(bus.meas_done), 0);
    check("rst_err",  32'(bus.meas_err), 0);
    check("rst_rise_r", 32'(bus.rising_delay_r), 0);

    // R fixed 3/5, G alternating 2,3 rise with fall 4, B zero skew
    set_ch(2, 3, 5, 8);
    set_ch(1, 0, 4, 8); alt[1] = 1'b1;
    set_ch(0, 0, 0, 8);
    pulse_start();
    check("start_busy", 32'(bus.meas_busy), 32'b111);
    run_wave(180);
    check("a_rise_r", 32'(bus.rising_delay_r), 3);
    check("a_fall_r", 32'(bus.falling_delay_r), 5);
    check("a_rise_g", 32'(bus.rising_delay_g), 2);
    check("a_fall_g", 32'(bus.falling_delay_g), 4);
    check("a_rise_b", 32'(bus.rising_delay_b), 0);
    check("a_fall_b", 32'(bus.falling_delay_b), 0);
    check("a_done", 32'(bus.meas_done), 32'b111);
    check("a_err",  32'(bus.meas_err), 0);

    // G clamp (12 -> 9), B stuck low times out, R 1/1
    set_ch(2, 1, 1, 8);
    set_ch(1, 12, 5, 8);
    set_ch(0, 0, 0, 8); stuck[0] = 1'b1;
    pulse_start();
    run_wave(180);
    check("b_rise_g_clamp", 32'(bus.rising_delay_g), 9);
    check("b_fall_g", 32'(bus.falling_delay_g), 5);
    check("b_rise_r", 32'(bus.rising_delay_r), 1);
    check("b_done", 32'(bus.meas_done), 32'b110);
    check("b_err",  32'(bus.meas_err), 32'b001);
    check("b_busy", 32'(bus.meas_busy), 32'b001);

    // R gets 8 pulses, G only 4, B none
    set_ch(2, 2, 2, 8);
    set_ch(1, 2, 2, 4);
    set_ch(0, 0, 0, 0);
    pulse_start();
    run_wave(180);
    check("c_done", 32'(bus.meas_done), 32'b100);
    check("c_busy", 32'(bus.meas_busy), 32'b011);
    check("c_rise_r", 32'(bus.rising_delay_r), 2);

    // Restart with G half-accumulated; stale samples would finish G early at 4
    pulse_start();
    check("restart_done", 32'(bus.meas_done), 0);
    check("restart_busy", 32'(bus.meas_busy), 32'b111);
    check("restart_err",  32'(bus.meas_err), 0);
    set_ch(2, 4, 6, 8);
    set_ch(1, 6, 6, 8);
    set_ch(0, 0, 0, 8);
    run_wave(180);
    check("d_rise_r", 32'(bus.rising_delay_r), 4);
    check("d_fall_r", 32'(bus.falling_delay_r), 6);
    check("d_rise_g", 32'(bus.rising_delay_g), 6);
    check("d_fall_g", 32'(bus.falling_delay_g), 6);
    check("d_done", 32'(bus.meas_done), 32'b111);

    // Single-cycle rx pulse at phase 2 on R while the rise is pending
    set_ch(2, 5, 3, 8); glitch[2] = 1'b1;
    set_ch(1, 0, 0, 0);
    set_ch(0, 0, 0, 0);
    pulse_start();
    run_wave(180);
`ifdef RX_GLITCH_FILT_EN
    check("g_rise_r", 32'(bus.rising_delay_r), 5);
`else
    check("g_rise_r", 32'(bus.rising_delay_r), 2);
`endif
    check("g_fall_r", 32'(bus.falling_delay_r), 3);
    check("g_done", 32'(bus.meas_done), 32'b100);

    // Asynchronous reset mid-run
    set_ch(2, 3, 3, 8);
    set_ch(1, 3, 3, 8);
    set_ch(0, 3, 3, 8);
    pulse_start();
    run_wave(30);
    check("m_busy_pre", 32'(bus.meas_busy), 32'b111);
    #2 g_rst = 1'b1;
    #1;
    check("m_busy",   32'(bus.meas_busy), 0);
    check("m_done",   32'(bus.meas_done), 0);
    check("m_err",    32'(bus.meas_err), 0);
    check("m_rise_r", 32'(bus.rising_delay_r), 0);
    check("m_fall_r", 32'(bus.falling_delay_r), 0);
    @(negedge clk_x10);
    g_rst = 1'b0;
    run_wave(60);
    check("idle_busy", 32'(bus.meas_busy), 0);
    check("idle_done", 32'(bus.meas_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
